// File: rtl/timer_responder.sv
// Memory-mapped down-counting timer on the MEM-stage data bus.
// CTRL/PRESET/COUNT registers, combinational read data, interrupt on expiry.
module timer_responder #(
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  Addr,
  input  logic        we,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        IRQ
);

  typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegPreset = 2'd1;
  localparam logic [1:0] RegCount  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_pending_q, irq_pending_d;

  logic wr_ctrl, wr_preset;
  logic ctrl_en, ctrl_auto;

  // Byte offset within a word carries no meaning here.
  logic unused_addr;
  assign unused_addr = ^Addr[1:0];

  assign wr_ctrl   = sel && we && (Addr[3:2] == RegCtrl);
  assign wr_preset = sel && we && (Addr[3:2] == RegPreset);
  assign ctrl_en   = ctrl_q[0];
  assign ctrl_auto = (ctrl_q[2:1] == 2'b01);

  // Zero-latency read mux, independent of sel/we.
  always_comb begin
    RData = 32'h0;
    unique case (Addr[3:2])
      RegCtrl:   RData = {28'h0, ctrl_q};
      RegPreset: RData = preset_q;
      RegCount:  RData = count_q;
      default:   RData = 32'h0;
    endcase
  end

  assign IRQ = irq_pending_q && ctrl_q[3];

  // Next-state: bus writes are applied first, then FSM effects layered on top
  // so that the expiry set of irq_pending beats a same-edge bus clear, while a
  // bus write to CTRL is reapplied last so it beats the one-shot EN clear.
  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    preset_d      = preset_q;
    count_d       = count_q;
    irq_pending_d = irq_pending_q;

    if (wr_preset) preset_d = WData;
    if (wr_ctrl || wr_preset) irq_pending_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_en) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!ctrl_en) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d       = 32'h0;
          irq_pending_d = 1'b1;
          state_d       = StInt;
        end
      end
      StInt: begin
        if (ctrl_auto) begin
          irq_pending_d = 1'b0;
          state_d       = StLoad;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_ctrl) ctrl_d = WData[3:0];
  end

  // State registers with synchronous reset overriding any bus write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      ctrl_q        <= 4'h0;
      preset_q      <= RESET_PRESET;
      count_q       <= 32'h0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      preset_q      <= preset_d;
      count_q       <= count_d;
      irq_pending_q <= irq_pending_d;
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
// Directed bench for timer_responder with an expected-value queue.
module tb_timer_responder;

  localparam logic [31:0] RP = 32'hA5A5_0003;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [3:0]  Addr;
  logic        we;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        IRQ;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q[$];

  timer_responder #(.RESET_PRESET(RP)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .Addr  (Addr),
    .we    (we),
    .WData (WData),
    .RData (RData),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; Addr = a; WData = d;
    tick();
    sel = 1'b0; we = 1'b0; WData = 32'h0;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h, expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h, expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [31:0] e);
    push(e);
    Addr = a;
    #1;
    chk(tag, RData);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    push({31'h0, e});
    chk(tag, {31'h0, IRQ});
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; Addr = 4'h0; WData = 32'h0;
    tickn(2);
    reset = 1'b0;

    // Reset state
    chk_rd("rst_ctrl", 4'h0, 32'h0);
    chk_rd("rst_preset", 4'h4, RP);
    chk_rd("rst_count", 4'h8, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // Reset mid-count
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h9);
    tickn(4);
    chk_rd("midcnt_count", 4'h8, 32'd8);
    reset = 1'b1;
    tickn(2);
    reset = 1'b0;
    chk_rd("mrst_count", 4'h8, 32'h0);
    chk_rd("mrst_ctrl", 4'h0, 32'h0);
    chk_rd("mrst_preset", 4'h4, RP);
    chk_irq("mrst_irq", 1'b0);

    // One-shot: PRESET at edge 0, CTRL at edge 1
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h9);
    tickn(2);
    chk_rd("os_count_e3", 4'h8, 32'd5);
    tickn(4);
    chk_rd("os_count_e7", 4'h8, 32'd1);
    chk_irq("os_irq_e7", 1'b0);
    tick();
    chk_irq("os_irq_e8", 1'b1);
    chk_rd("os_count_e8", 4'h8, 32'd0);
    tick();
    chk_rd("os_ctrl_e9", 4'h0, 32'h8);
    chk_irq("os_irq_e9", 1'b1);
    tickn(2);
    chk_irq("os_irq_hold", 1'b1);
    wr(4'h0, 32'h0);
    chk_irq("os_irq_clr", 1'b0);

    // Masked run: IRQ never rises, COUNT still reaches 0
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_irq("mask_irq", 1'b0);
    end
    chk_rd("mask_count", 4'h8, 32'd0);
    chk_rd("mask_ctrl", 4'h0, 32'h0);

    // Auto-reload: pulses every N+2 = 5 cycles
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      push({31'h0, (k == 5) || (k == 10) || (k == 15)});
      tick();
      chk("auto_irq", {31'h0, IRQ});
    end
    chk_rd("auto_ctrl", 4'h0, 32'hB);
    wr(4'h0, 32'h0);
    tickn(3);

    // PRESET=0 and PRESET=1 expire one cycle after load
    for (int p = 0; p <= 1; p++) begin
      wr(4'h4, p);
      wr(4'h0, 32'h9);
      tickn(2);
      chk_rd("bnd_count", 4'h8, p);
      chk_irq("bnd_irq_lo", 1'b0);
      tick();
      chk_irq("bnd_irq_hi", 1'b1);
      wr(4'h0, 32'h0);
      chk_irq("bnd_irq_clr", 1'b0);
      tickn(2);
    end

    // Pause at COUNT=6 and re-enable
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);
    tickn(5);
    chk_rd("pause_count7", 4'h8, 32'd7);
    wr(4'h0, 32'h0);
    tickn(3);
    chk_rd("pause_hold", 4'h8, 32'd6);
    wr(4'h0, 32'h1);
    tickn(2);
    chk_rd("resume_reload", 4'h8, 32'd10);
    wr(4'h0, 32'h0);
    tickn(3);
    chk_rd("stop_count", 4'h8, 32'd9);

    // Writes to COUNT and reserved slot are ignored
    wr(4'h8, 32'h1234);
    chk_rd("wr_count_ign", 4'h8, 32'd9);
    wr(4'hC, 32'hFFFF_FFFF);
    chk_rd("rsvd_read", 4'hC, 32'h0);
    chk_rd("rsvd_count", 4'h8, 32'd9);
    chk_rd("rsvd_ctrl", 4'h0, 32'h0);
    chk_rd("rsvd_preset", 4'h5, 32'd10);

    // PRESET write mid-count affects only the next load
    wr(4'h4, 32'd4);
    wr(4'h0, 32'h9);
    tickn(2);
    chk_rd("pw_count_start", 4'h8, 32'd4);
    wr(4'h4, 32'd20);
    chk_rd("pw_count_run", 4'h8, 32'd3);
    tickn(3);
    chk_irq("pw_irq", 1'b1);
    tickn(2);
    wr(4'h0, 32'h9);
    tickn(2);
    chk_rd("pw_reload_new", 4'h8, 32'd20);
    wr(4'h0, 32'h0);
    tickn(3);

    // Upper CTRL bits are not stored
    wr(4'h0, 32'hFFFF_FFFF);
    chk_rd("ctrl_mask", 4'h0, 32'h0000_000F);
    wr(4'h0, 32'h0);
    tickn(3);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_responder.md
Name: timer_responder

Overview:
Memory-mapped down-counting timer that answers the CPU's data-side load/store accesses. The pipeline initiates MEM-stage accesses; this block decodes them, holds CTRL/PRESET/COUNT registers, and raises an interrupt request on expiry. It sits beside data memory on the MEM-stage bus. An external address decoder asserts sel when the MEM-stage address falls in this block's window.

Parameters:
RESET_PRESET, 32'h0, value loaded into PRESET on reset.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on a rising edge where high
sel  input  1  access targets this block (MEM-stage address in window)
Addr  input  4  byte offset in window; Addr[3:2] selects register, Addr[1:0] ignored
we  input  1  store strobe; write occurs when sel && we at a rising edge
WData  input  32  store data
RData  output  32  read data, combinational from Addr
IRQ  output  1  interrupt request = irq_pending && CTRL[3]

Behaviour:
- Register map (Addr[3:2]):
  - 0 = CTRL [3:0]: bit0 EN, bits2:1 MODE, bit3 IM. Bits [31:4] read as 0 and are not stored.
  - 1 = PRESET, 32-bit read/write.
  - 2 = COUNT, 32-bit, read-only; writes ignored.
  - 3 = reserved; reads 0, writes ignored.
- RData is combinational (zero latency), independent of sel and we.
- Reset values: CTRL=0, PRESET=RESET_PRESET, COUNT=0, state=IDLE, irq_pending=0. Therefore RData at Addr 0 is 0 and IRQ=0.
- Reset is honoured in every state, including mid-count or in INT. Reset overrides any simultaneous bus write.
- State machine (2-bit state):
  - IDLE: if EN → LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; → CNT.
  - CNT: if EN=0 → IDLE, COUNT holds its value.
  - CNT, EN=1, COUNT>1: COUNT <= COUNT-1.
  - CNT, EN=1, COUNT<=1: COUNT <= 0; irq_pending <= 1; → INT.
  - INT, MODE=01 (auto-reload): irq_pending <= 0; → LOAD.
  - INT, MODE=00/10/11 (one-shot): CTRL.EN <= 0; irq_pending held; → IDLE.
- One-shot irq_pending clears on any bus write to CTRL or PRESET (sel && we, Addr[3:2] in {0,1}). It is also cleared by reset.
- Simultaneous events:
  - A bus write to CTRL in the same edge as the INT one-shot EN clear: the bus write wins, so CTRL takes WData[3:0].
  - A bus write that clears irq_pending in the same edge as CNT→INT: the set wins, so irq_pending=1.
  - A PRESET write during CNT does not affect the running COUNT; it takes effect at the next LOAD.
- Arithmetic: COUNT is unsigned 32-bit. Decrement never wraps because COUNT<=1 terminates the count.
- PRESET=0 and PRESET=1 both expire one cycle after LOAD.
- Latency: EN written at edge t → LOAD at t+1 → COUNT=N at t+2 → INT and irq_pending at t+N+2 (N>=1).
- Auto-reload IRQ is a single-cycle pulse with a period of N+2 cycles.

Test Plan:
- Reset: assert reset 2 cycles mid-count (PRESET=10, CTRL=9) → next cycle COUNT=0, CTRL=0, IRQ=0, RData(Addr 4)=RESET_PRESET.
- One-shot: write PRESET=5 at edge 0, CTRL=0x9 at edge 1 → COUNT=5 at edge 3, 1 at edge 7; IRQ rises at edge 8 and stays high; CTRL reads 0x8 from edge 9.
- IRQ clear and mask: after the one-shot case, write CTRL=0x0 → IRQ low next cycle. Repeat the run with IM=0 (CTRL=0x1) → IRQ never rises, COUNT still reaches 0.
- Auto-reload: PRESET=3, CTRL=0xB → IRQ 1-cycle pulses at 5-cycle spacing for at least 3 periods; CTRL.EN stays 1.
- Boundary presets and pause: PRESET=0 and PRESET=1 → IRQ one cycle after COUNT loads. PRESET=10, clear EN at COUNT=6 → COUNT holds 6. Re-enable → reload to 10.
- Bus edge cases: write to COUNT and to Addr 0xC → no state change. PRESET write mid-count → current run unaffected, next reload uses the new value. Read CTRL after writing 0xFFFFFFFF → 0x0000000F.
